// File: rtl/oled_pkg.sv
// Shared definitions for the OLED pattern sequencer: RGB565 palette,
// sequencer state encoding and pattern indices.
package oled_pkg;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] WHITE   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_RUN       = 2'd1,
        ST_PAUSED    = 2'd2
    } state_e;

    localparam logic [1:0] PAT_CHECKER  = 2'd0;
    localparam logic [1:0] PAT_BARS     = 2'd1;
    localparam logic [1:0] PAT_GRADIENT = 2'd2;
    localparam logic [1:0] PAT_DIAGONAL = 2'd3;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BLACK;
            3'd1:    c = BLUE;
            3'd2:    c = GREEN;
            3'd3:    c = CYAN;
            3'd4:    c = RED;
            3'd5:    c = MAGENTA;
            3'd6:    c = YELLOW;
            3'd7:    c = WHITE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/oled_pattern_gen.sv
// Combinational pixel colour generator: maps (x, y, pattern, scroll) to RGB565.
module oled_pattern_gen
    import oled_pkg::*;
(
    input  logic [6:0]  x_i,
    input  logic [7:0]  y_i,
    input  logic [1:0]  pattern_i,
    input  logic [7:0]  scroll_i,
    output logic [15:0] color_o
);

    logic [6:0] xs_s;
    logic [7:0] diag_s;

    // Colour lookup for the active pattern; scroll only shifts horizontally.
    always_comb begin
        xs_s    = x_i + scroll_i[6:0];
        diag_s  = {1'b0, x_i} + y_i + scroll_i;
        color_o = BLACK;
        case (pattern_i)
            PAT_CHECKER:  color_o = (xs_s[3] ^ y_i[3]) ? GREEN : RED;
            PAT_BARS:     color_o = bar_color(xs_s[6:4]);
            PAT_GRADIENT: color_o = {5'd0, y_i[5:0], 5'd0};
            PAT_DIAGONAL: color_o = diag_s[4] ? WHITE : BLUE;
            default:      color_o = BLACK;
        endcase
    end

endmodule

// File: rtl/oled_pattern_sequencer.sv
// Frame-level pattern scheduler: detects frame starts from the x/y raster and
// switches pattern/scroll only on frame boundaries so frames never tear.
module oled_pattern_sequencer
    import oled_pkg::*;
#(
    parameter int C_dwell_frames = 60,
    parameter int C_num_patterns = 4,
    parameter int C_auto         = 1
) (
    input  logic        clki,
    input  logic        rst,
    input  logic [6:0]  x,
    input  logic [7:0]  y,
    input  logic        pause,
    input  logic        next,
    output logic [15:0] color,
    output logic [1:0]  pattern,
    output logic        frame_tick
);

    localparam logic [7:0] DWELL_LAST = 8'(C_dwell_frames - 1);
    localparam logic [1:0] PAT_LAST   = 2'(C_num_patterns - 1);
    localparam bit         AUTO_EN    = (C_auto != 0);

    state_e      state_q, state_d;
    logic [1:0]  pattern_q, pattern_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  scroll_q, scroll_d;
    logic        pending_q, pending_d;
    logic [6:0]  prev_x_q;
    logic [7:0]  prev_y_q;
    logic        frame_tick_q;
    logic        frame_start_s;
    logic [15:0] gen_color_s;

    // A held (0,0) must count once, hence the comparison with the previous sample.
    assign frame_start_s = (x == 7'd0) && (y == 8'd0) &&
                           !((prev_x_q == 7'd0) && (prev_y_q == 8'd0));

    // Next-state logic; all scheduling decisions are gated by frame_start_s.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        frame_cnt_d = frame_cnt_q;
        scroll_d    = scroll_q;
        pending_d   = pending_q;
        case (state_q)
            ST_WAIT_SYNC: begin
                if (frame_start_s) state_d = ST_RUN;
                else               state_d = ST_WAIT_SYNC;
            end
            ST_RUN: begin
                if (!frame_start_s) begin
                    state_d = ST_RUN;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (pending_q || (AUTO_EN && (frame_cnt_q == DWELL_LAST))) begin
                    pattern_d   = (pattern_q == PAT_LAST) ? 2'd0 : pattern_q + 2'd1;
                    frame_cnt_d = 8'd0;
                    scroll_d    = 8'd0;
                    pending_d   = 1'b0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    scroll_d    = scroll_q + 8'd1;
                end
            end
            ST_PAUSED: begin
                if (frame_start_s && !pause) state_d = ST_RUN;
                else                         state_d = ST_PAUSED;
            end
            default: state_d = ST_WAIT_SYNC;
        endcase
        // A request arriving on a consuming boundary re-arms pending.
        if (next && (state_q != ST_WAIT_SYNC)) pending_d = 1'b1;
        else                                   pending_d = pending_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clki) begin
        if (rst) begin
            state_q      <= ST_WAIT_SYNC;
            pattern_q    <= 2'd0;
            frame_cnt_q  <= 8'd0;
            scroll_q     <= 8'd0;
            pending_q    <= 1'b0;
            prev_x_q     <= 7'h7F;
            prev_y_q     <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            frame_cnt_q  <= frame_cnt_d;
            scroll_q     <= scroll_d;
            pending_q    <= pending_d;
            prev_x_q     <= x;
            prev_y_q     <= y;
            frame_tick_q <= frame_start_s;
        end
    end

    oled_pattern_gen u_gen (
        .x_i       (x),
        .y_i       (y),
        .pattern_i (pattern_q),
        .scroll_i  (scroll_q),
        .color_o   (gen_color_s)
    );

    assign color      = (state_q == ST_WAIT_SYNC) ? BLACK : gen_color_s;
    assign pattern    = pattern_q;
    assign frame_tick = frame_tick_q;

endmodule
